// File: rtl/render_pkg.sv
// Shared rendering types, default screen size and the triangle-setup FSM encoding.
// Small helpers for bounding-box reduction and screen clamping live here too.
package render_pkg;

  typedef logic signed [31:0] vtx_fixed_t;
  typedef logic signed [15:0] pix_t;
  typedef logic signed [16:0] edge_ab_t;
  typedef logic signed [32:0] edge_c_t;
  typedef logic signed [34:0] area_t;

  localparam int DEF_SCREEN_W = 320;
  localparam int DEF_SCREEN_H = 240;

  typedef enum logic [1:0] {
    S_COLLECT = 2'd0,
    S_EDGE    = 2'd1,
    S_AREA    = 2'd2,
    S_EMIT    = 2'd3
  } setup_state_t;

  function automatic pix_t min3(pix_t a, pix_t b, pix_t c);
    pix_t m;
    m = (a < b) ? a : b;
    return (c < m) ? c : m;
  endfunction

  function automatic pix_t max3(pix_t a, pix_t b, pix_t c);
    pix_t m;
    m = (a > b) ? a : b;
    return (c > m) ? c : m;
  endfunction

  // Negative coordinates pin to 0, anything past the last pixel pins to lim.
  function automatic logic [9:0] clamp_pix(pix_t p, pix_t lim);
    logic [9:0] r;
    if (p < 16'sd0)
      r = 10'd0;
    else if (p > lim)
      r = lim[9:0];
    else
      r = p[9:0];
    return r;
  endfunction

endpackage

// File: rtl/edge_coeff.sv
// Combinational edge-function coefficients for the directed edge (x0,y0) -> (x1,y1).
// The top time-multiplexes one instance over the three edges of a triangle.
module edge_coeff
  import render_pkg::*;
(
  input  pix_t     x0,
  input  pix_t     y0,
  input  pix_t     x1,
  input  pix_t     y1,
  output edge_ab_t a,
  output edge_ab_t b,
  output edge_c_t  c
);

  logic signed [31:0] prod0;
  logic signed [31:0] prod1;

  assign prod0 = x0 * y1;
  assign prod1 = x1 * y0;

  assign a = edge_ab_t'(y0) - edge_ab_t'(y1);
  assign b = edge_ab_t'(x1) - edge_ab_t'(x0);
  assign c = edge_c_t'(prod0) - edge_c_t'(prod1);

endmodule

// File: rtl/triangle_setup.sv
// Triangle setup: gathers three vertices, derives edge functions, area and clamped bbox,
// culls degenerate/back-facing/off-screen triangles and offers the rest over valid/ready.
module triangle_setup
  import render_pkg::*;
#(
  parameter int SCREEN_W      = DEF_SCREEN_W,
  parameter int SCREEN_H      = DEF_SCREEN_H,
  parameter bit CULL_BACKFACE = 1'b1
)
(
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_vtx_valid,
  output logic        o_vtx_ready,
  input  vtx_fixed_t  i_vtx_x,
  input  vtx_fixed_t  i_vtx_y,
  output logic        o_tri_valid,
  input  logic        i_tri_ready,
  output edge_ab_t    o_edge_a [3],
  output edge_ab_t    o_edge_b [3],
  output edge_c_t     o_edge_c [3],
  output area_t       o_area2,
  output logic [9:0]  o_bb_xmin,
  output logic [9:0]  o_bb_xmax,
  output logic [9:0]  o_bb_ymin,
  output logic [9:0]  o_bb_ymax,
  output logic [15:0] o_tri_count,
  output logic [15:0] o_cull_count
);

  localparam pix_t XLIM = pix_t'(SCREEN_W - 1);
  localparam pix_t YLIM = pix_t'(SCREEN_H - 1);

  setup_state_t state;
  logic [1:0]   cnt;
  logic [1:0]   ecnt;
  logic [1:0]   enxt;
  pix_t         vx [3];
  pix_t         vy [3];
  edge_ab_t     ea;
  edge_ab_t     eb;
  edge_c_t      ec;
  area_t        area_sum;
  pix_t         xmin, xmax, ymin, ymax;
  logic         neg_area;
  logic         off_screen;
  logic         cull;
  logic         unused_frac;

  // Only the integer part of each Q16.16 coordinate is used (floor).
  assign unused_frac = ^{i_vtx_x[15:0], i_vtx_y[15:0]};

  assign o_vtx_ready = i_rst_n && (state == S_COLLECT);
  assign o_tri_valid = (state == S_EMIT);
  assign enxt        = (ecnt == 2'd2) ? 2'd0 : ecnt + 2'd1;

  edge_coeff u_edge (
    .x0 (vx[ecnt]),
    .y0 (vy[ecnt]),
    .x1 (vx[enxt]),
    .y1 (vy[enxt]),
    .a  (ea),
    .b  (eb),
    .c  (ec)
  );

  always_comb begin
    area_sum   = area_t'(o_edge_c[0]) + area_t'(o_edge_c[1]) + area_t'(o_edge_c[2]);
    xmin       = min3(vx[0], vx[1], vx[2]);
    xmax       = max3(vx[0], vx[1], vx[2]);
    ymin       = min3(vy[0], vy[1], vy[2]);
    ymax       = max3(vy[0], vy[1], vy[2]);
    neg_area   = area_sum[34];
    off_screen = (xmax < 16'sd0) || (xmin > XLIM) || (ymax < 16'sd0) || (ymin > YLIM);
    cull       = (area_sum == '0) || (neg_area && CULL_BACKFACE) || off_screen;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state        <= S_COLLECT;
      cnt          <= '0;
      ecnt         <= '0;
      o_area2      <= '0;
      o_bb_xmin    <= '0;
      o_bb_xmax    <= '0;
      o_bb_ymin    <= '0;
      o_bb_ymax    <= '0;
      o_tri_count  <= '0;
      o_cull_count <= '0;
      for (int i = 0; i < 3; i++) begin
        vx[i]       <= '0;
        vy[i]       <= '0;
        o_edge_a[i] <= '0;
        o_edge_b[i] <= '0;
        o_edge_c[i] <= '0;
      end
    end else begin
      case (state)
        S_COLLECT: begin
          if (i_vtx_valid) begin
            vx[cnt] <= i_vtx_x[31:16];
            vy[cnt] <= i_vtx_y[31:16];
            if (cnt == 2'd2) begin
              cnt   <= '0;
              ecnt  <= '0;
              state <= S_EDGE;
            end else begin
              cnt <= cnt + 2'd1;
            end
          end
        end
        S_EDGE: begin
          o_edge_a[ecnt] <= ea;
          o_edge_b[ecnt] <= eb;
          o_edge_c[ecnt] <= ec;
          ecnt           <= enxt;
          if (ecnt == 2'd2)
            state <= S_AREA;
        end
        S_AREA: begin
          if (cull) begin
            o_cull_count <= o_cull_count + 16'd1;
            state        <= S_COLLECT;
          end else begin
            // Clockwise triangles that survive are re-wound so area2 is always positive.
            o_area2 <= neg_area ? -area_sum : area_sum;
            if (neg_area) begin
              for (int i = 0; i < 3; i++) begin
                o_edge_a[i] <= -o_edge_a[i];
                o_edge_b[i] <= -o_edge_b[i];
                o_edge_c[i] <= -o_edge_c[i];
              end
            end
            o_bb_xmin <= clamp_pix(xmin, XLIM);
            o_bb_xmax <= clamp_pix(xmax, XLIM);
            o_bb_ymin <= clamp_pix(ymin, YLIM);
            o_bb_ymax <= clamp_pix(ymax, YLIM);
            state     <= S_EMIT;
          end
        end
        S_EMIT: begin
          if (i_tri_ready) begin
            o_tri_count <= o_tri_count + 16'd1;
            state       <= S_COLLECT;
          end
        end
        default: state <= S_COLLECT;
      endcase
    end
  end

endmodule

// File: tb/tb_triangle_setup.sv
// Bench for triangle_setup: one culling and one re-winding instance share the stimulus and are
// compared against a plain-arithmetic triangle model plus a table of hand-derived cases.
module tb_triangle_setup;
  import render_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        vtx_valid;
  logic        tri_ready;
  vtx_fixed_t  vtx_x, vtx_y;

  logic        c_vtx_ready, c_tri_valid, n_vtx_ready, n_tri_valid;
  edge_ab_t    c_a [3], c_b [3], n_a [3], n_b [3];
  edge_c_t     c_c [3], n_c [3];
  area_t       c_area, n_area;
  logic [9:0]  c_bb [4], n_bb [4];
  logic [15:0] c_tcnt, c_ccnt, n_tcnt, n_ccnt;

  int checks = 0;
  int errors = 0;

  // Model state: inputs, edge terms, area and expected outcome for each instance.
  int     mx [3], my [3];
  longint ma [3], mb [3], mc [3], marea;
  longint na [3], nb [3], nc [3], narea;
  int     mbb [4];
  bit     emit_c, emit_n;
  int     exp_ctri, exp_ccull, exp_ntri, exp_ncull;

  logic       snap_valid;
  area_t      snap_area;
  logic [9:0] snap_bb [4];

  typedef struct {
    int     x0, y0, x1, y1, x2, y2;
    bit     emit;
    longint area;
    int     bxmin, bxmax, bymin, bymax;
  } vec_t;

  vec_t tv [6];
  int   k1a [3], k1b [3], k1c [3], k2a [3], k2b [3], k2c [3];

  always #5 clk = ~clk;

  triangle_setup #(.SCREEN_W(320), .SCREEN_H(240), .CULL_BACKFACE(1'b1)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_vtx_valid(vtx_valid), .o_vtx_ready(c_vtx_ready),
    .i_vtx_x(vtx_x), .i_vtx_y(vtx_y), .o_tri_valid(c_tri_valid), .i_tri_ready(tri_ready),
    .o_edge_a(c_a), .o_edge_b(c_b), .o_edge_c(c_c), .o_area2(c_area),
    .o_bb_xmin(c_bb[0]), .o_bb_xmax(c_bb[1]), .o_bb_ymin(c_bb[2]), .o_bb_ymax(c_bb[3]),
    .o_tri_count(c_tcnt), .o_cull_count(c_ccnt)
  );

  triangle_setup #(.SCREEN_W(320), .SCREEN_H(240), .CULL_BACKFACE(1'b0)) dut_nc (
    .i_clk(clk), .i_rst_n(rst_n), .i_vtx_valid(vtx_valid), .o_vtx_ready(n_vtx_ready),
    .i_vtx_x(vtx_x), .i_vtx_y(vtx_y), .o_tri_valid(n_tri_valid), .i_tri_ready(tri_ready),
    .o_edge_a(n_a), .o_edge_b(n_b), .o_edge_c(n_c), .o_area2(n_area),
    .o_bb_xmin(n_bb[0]), .o_bb_xmax(n_bb[1]), .o_bb_ymin(n_bb[2]), .o_bb_ymax(n_bb[3]),
    .o_tri_count(n_tcnt), .o_cull_count(n_ccnt)
  );

  task automatic checkOutput(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Triangle math straight from geometry: signed doubled area as a cross product.
  function automatic void refModel();
    int  xlo, xhi, ylo, yhi;
    bit  off;
    longint s;
    xlo = mx[0]; xhi = mx[0]; ylo = my[0]; yhi = my[0];
    for (int k = 1; k < 3; k++) begin
      if (mx[k] < xlo) xlo = mx[k];
      if (mx[k] > xhi) xhi = mx[k];
      if (my[k] < ylo) ylo = my[k];
      if (my[k] > yhi) yhi = my[k];
    end
    for (int k = 0; k < 3; k++) begin
      int j;
      j = (k + 1) % 3;
      ma[k] = my[k] - my[j];
      mb[k] = mx[j] - mx[k];
      mc[k] = longint'(mx[k]) * my[j] - longint'(mx[j]) * my[k];
    end
    marea = longint'(mx[1] - mx[0]) * (my[2] - my[0]) - longint'(mx[2] - mx[0]) * (my[1] - my[0]);
    off = (xhi < 0) || (xlo > 319) || (yhi < 0) || (ylo > 239);
    emit_c = !off && (marea > 0);
    emit_n = !off && (marea != 0);
    s = (marea < 0) ? -1 : 1;
    for (int k = 0; k < 3; k++) begin
      na[k] = s * ma[k];
      nb[k] = s * mb[k];
      nc[k] = s * mc[k];
    end
    narea = s * marea;
    mbb[0] = (xlo < 0) ? 0 : ((xlo > 319) ? 319 : xlo);
    mbb[1] = (xhi < 0) ? 0 : ((xhi > 319) ? 319 : xhi);
    mbb[2] = (ylo < 0) ? 0 : ((ylo > 239) ? 239 : ylo);
    mbb[3] = (yhi < 0) ? 0 : ((yhi > 239) ? 239 : yhi);
  endfunction

  task automatic driveVertex(input int v);
    int waited;
    waited = 0;
    while (!(c_vtx_ready && n_vtx_ready) && waited < 40) begin
      @(negedge clk);
      waited++;
    end
    if (waited >= 40) checkOutput("ready_timeout", 0, 1);
    vtx_x     = {mx[v][15:0], 16'($urandom)};
    vtx_y     = {my[v][15:0], 16'($urandom)};
    vtx_valid = 1'b1;
    @(negedge clk);
    vtx_valid = 1'b0;
  endtask

  // Sends mx/my as one triangle and checks latency, outputs, backpressure and counters.
  task automatic applyStimulus(input int hold);
    refModel();
    tri_ready = (hold == 0);
    for (int v = 0; v < 3; v++) driveVertex(v);
    for (int e = 1; e <= 3; e++) begin
      @(negedge clk);
      checkOutput("busy_cycle", {c_tri_valid, c_vtx_ready, n_tri_valid, n_vtx_ready}, 0);
    end
    @(negedge clk);
    checkOutput("c_valid_latency", c_tri_valid, emit_c);
    checkOutput("n_valid_latency", n_tri_valid, emit_n);
    checkOutput("c_ready_after", c_vtx_ready, !emit_c);
    checkOutput("n_ready_after", n_vtx_ready, !emit_n);
    exp_ccull += emit_c ? 0 : 1;
    exp_ncull += emit_n ? 0 : 1;
    checkOutput("c_cull_count", c_ccnt, exp_ccull & 16'hFFFF);
    checkOutput("n_cull_count", n_ccnt, exp_ncull & 16'hFFFF);
    if (emit_c) begin
      checkOutput("c_area2", c_area, marea);
      for (int k = 0; k < 3; k++) begin
        checkOutput($sformatf("c_a%0d", k), c_a[k], ma[k]);
        checkOutput($sformatf("c_b%0d", k), c_b[k], mb[k]);
        checkOutput($sformatf("c_c%0d", k), c_c[k], mc[k]);
      end
      for (int k = 0; k < 4; k++) checkOutput($sformatf("c_bb%0d", k), c_bb[k], mbb[k]);
    end
    if (emit_n) begin
      checkOutput("n_area2", n_area, narea);
      for (int k = 0; k < 3; k++) begin
        checkOutput($sformatf("n_a%0d", k), n_a[k], na[k]);
        checkOutput($sformatf("n_b%0d", k), n_b[k], nb[k]);
        checkOutput($sformatf("n_c%0d", k), n_c[k], nc[k]);
      end
      for (int k = 0; k < 4; k++) checkOutput($sformatf("n_bb%0d", k), n_bb[k], mbb[k]);
    end
    snap_valid = c_tri_valid;
    snap_area  = c_area;
    for (int k = 0; k < 4; k++) snap_bb[k] = c_bb[k];
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      checkOutput("hold_valid", {c_tri_valid, n_tri_valid}, {emit_c, emit_n});
      checkOutput("hold_ready", {c_vtx_ready, n_vtx_ready}, {!emit_c, !emit_n});
      if (emit_c) begin
        checkOutput("hold_c_area", c_area, marea);
        checkOutput("hold_c_xmax", c_bb[1], mbb[1]);
        checkOutput("hold_c_c0", c_c[0], mc[0]);
      end
    end
    tri_ready = 1'b1;
    if (emit_c || emit_n) begin
      @(negedge clk);
      exp_ctri += emit_c ? 1 : 0;
      exp_ntri += emit_n ? 1 : 0;
      checkOutput("ready_after_emit", {c_vtx_ready, n_vtx_ready}, 2'b11);
      checkOutput("valid_after_emit", {c_tri_valid, n_tri_valid}, 2'b00);
      checkOutput("c_tri_count", c_tcnt, exp_ctri & 16'hFFFF);
      checkOutput("n_tri_count", n_tcnt, exp_ntri & 16'hFFFF);
    end
  endtask

  task automatic checkResetState();
    checkOutput("rst_ready", {c_vtx_ready, n_vtx_ready}, 0);
    checkOutput("rst_valid", {c_tri_valid, n_tri_valid}, 0);
    checkOutput("rst_area", c_area, 0);
    checkOutput("rst_edge", {c_a[0], c_b[1], c_c[2]}, 0);
    checkOutput("rst_bbox", {c_bb[0], c_bb[1], c_bb[2], c_bb[3]}, 0);
    checkOutput("rst_counts", {c_tcnt, c_ccnt, n_tcnt, n_ccnt}, 0);
  endtask

  task automatic loadVec(input vec_t t);
    mx[0] = t.x0; my[0] = t.y0;
    mx[1] = t.x1; my[1] = t.y1;
    mx[2] = t.x2; my[2] = t.y2;
  endtask

  initial begin
    tv[0] = '{10, 10, 50, 10, 10, 40, 1'b1, 1200, 10, 50, 10, 40};
    tv[1] = '{10, 10, 10, 40, 50, 10, 1'b0, 0, 0, 0, 0, 0};
    tv[2] = '{0, 0, 10, 10, 20, 20, 1'b0, 0, 0, 0, 0, 0};
    tv[3] = '{-20, -5, 400, 100, 100, 300, 1'b1, 115500, 0, 319, 0, 239};
    tv[4] = '{400, 0, 450, 0, 400, 50, 1'b0, 0, 0, 0, 0, 0};
    tv[5] = '{-30, -30, -10, -30, -30, -10, 1'b0, 0, 0, 0, 0, 0};
    k1a = '{0, -30, 30};     k1b = '{40, -40, 0};   k1c = '{-400, 1900, -300};
    k2a = '{30, -30, 0};     k2b = '{0, -40, 40};   k2c = '{-300, 1900, -400};

    rst_n = 1'b0; vtx_valid = 1'b0; tri_ready = 1'b1; vtx_x = '0; vtx_y = '0;
    exp_ctri = 0; exp_ccull = 0; exp_ntri = 0; exp_ncull = 0;
    repeat (3) @(negedge clk);
    checkResetState();
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 6; i++) begin
      loadVec(tv[i]);
      applyStimulus(0);
      checkOutput($sformatf("tab%0d_emit", i), snap_valid, tv[i].emit);
      if (tv[i].emit) begin
        checkOutput($sformatf("tab%0d_area", i), snap_area, tv[i].area);
        checkOutput($sformatf("tab%0d_xmin", i), snap_bb[0], tv[i].bxmin);
        checkOutput($sformatf("tab%0d_xmax", i), snap_bb[1], tv[i].bxmax);
        checkOutput($sformatf("tab%0d_ymin", i), snap_bb[2], tv[i].bymin);
        checkOutput($sformatf("tab%0d_ymax", i), snap_bb[3], tv[i].bymax);
      end
      if (i == 0) begin
        for (int k = 0; k < 3; k++) begin
          checkOutput($sformatf("case1_a%0d", k), c_a[k], k1a[k]);
          checkOutput($sformatf("case1_b%0d", k), c_b[k], k1b[k]);
          checkOutput($sformatf("case1_c%0d", k), c_c[k], k1c[k]);
        end
      end
      if (i == 1) begin
        checkOutput("case2_n_area", n_area, 1200);
        for (int k = 0; k < 3; k++) begin
          checkOutput($sformatf("case2_n_a%0d", k), n_a[k], k2a[k]);
          checkOutput($sformatf("case2_n_b%0d", k), n_b[k], k2b[k]);
          checkOutput($sformatf("case2_n_c%0d", k), n_c[k], k2c[k]);
        end
      end
    end

    // Backpressure on case 1: outputs frozen for 10 cycles, ready one cycle after release.
    loadVec(tv[0]);
    applyStimulus(10);

    // Reset with two vertices pending: the partial triangle and counters vanish.
    loadVec(tv[0]);
    tri_ready = 1'b1;
    driveVertex(0);
    driveVertex(1);
    rst_n = 1'b0;
    #1;
    checkResetState();
    @(negedge clk);
    rst_n = 1'b1;
    exp_ctri = 0; exp_ccull = 0; exp_ntri = 0; exp_ncull = 0;
    @(negedge clk);
    loadVec(tv[0]);
    applyStimulus(0);
    checkOutput("rst_case1_count", c_tcnt, 1);
    checkOutput("rst_case1_area", snap_area, 1200);

    for (int r = 0; r < 40; r++) begin
      for (int v = 0; v < 3; v++) begin
        mx[v] = int'($urandom_range(0, 460)) - 60;
        my[v] = int'($urandom_range(0, 360)) - 60;
      end
      applyStimulus(int'($urandom_range(0, 3)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
